// File: rtl/led_status_ctrl.sv
// Multi-channel LED status controller: shared tick prescaler and blink phase,
// per-channel event pulse-stretchers, per-channel 2-bit mode select and a
// global PWM brightness gate. Everything lives in the sys_clk domain.
// evt[i] is the per-channel activity strobe and must already be synchronous to sys_clk.
module led_status_ctrl #(
  parameter int unsigned NCH               = 8,
  parameter int unsigned CLK_DIV           = 100_000,
  parameter int unsigned HALF_PERIOD_TICKS = 500,
  parameter int unsigned STRETCH_TICKS     = 50,
  parameter int unsigned PWM_BITS          = 4
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [2*NCH-1:0]    mode,
  input  logic [NCH-1:0]      evt,
  input  logic [PWM_BITS-1:0] duty,
  output logic [NCH-1:0]      led,
  output logic                tick
);

  localparam int unsigned PW  = $clog2(CLK_DIV);
  localparam int unsigned PhW = (HALF_PERIOD_TICKS > 1) ? $clog2(HALF_PERIOD_TICKS) : 1;
  localparam int unsigned SW  = $clog2(STRETCH_TICKS + 1);

  localparam logic [PW-1:0]  PresLast    = PW'(CLK_DIV - 1);
  localparam logic [PhW-1:0] PhaseLast   = PhW'(HALF_PERIOD_TICKS - 1);
  localparam logic [SW-1:0]  StretchLoad = SW'(STRETCH_TICKS);

  typedef enum logic [1:0] {
    ModeOff     = 2'b00,
    ModeOn      = 2'b01,
    ModeBlink   = 2'b10,
    ModeStretch = 2'b11
  } mode_e;

  logic [PW-1:0]              presc_q, presc_d;
  logic                       tick_q, tick_d;
  logic [PhW-1:0]             phase_q, phase_d;
  logic                       blink_q, blink_d;
  logic [NCH-1:0][SW-1:0]     stretch_q, stretch_d;
  logic [PWM_BITS-1:0]        pwm_q, pwm_d;
  logic [NCH-1:0]             led_q, led_d;
  logic [NCH-1:0]             raw;
  logic                       gate;

  assign led  = led_q;
  assign tick = tick_q;

  // Next-state for prescaler, blink phase, stretchers, PWM counter and LED drive.
  always_comb begin
    presc_d   = (presc_q == PresLast) ? '0 : presc_q + PW'(1);
    tick_d    = (presc_q == PresLast);

    phase_d   = phase_q;
    blink_d   = blink_q;
    if (tick_q) begin
      if (phase_q == PhaseLast) begin
        phase_d = '0;
        blink_d = ~blink_q;
      end else begin
        phase_d = phase_q + PhW'(1);
      end
    end

    stretch_d = stretch_q;
    for (int i = 0; i < int'(NCH); i++) begin
      // A fresh event always wins over a same-cycle tick decrement.
      if (evt[i]) begin
        stretch_d[i] = StretchLoad;
      end else if (tick_q && (stretch_q[i] != '0)) begin
        stretch_d[i] = stretch_q[i] - SW'(1);
      end
    end

    pwm_d = pwm_q + PWM_BITS'(1);
    // All-ones duty bypasses the comparator so full brightness has no ripple.
    gate  = (pwm_q < duty) || (&duty);

    raw = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      unique case (mode_e'(mode[2*i +: 2]))
        ModeOff:     raw[i] = 1'b0;
        ModeOn:      raw[i] = 1'b1;
        ModeBlink:   raw[i] = blink_q;
        ModeStretch: raw[i] = (stretch_q[i] != '0);
        default:     raw[i] = 1'b0;
      endcase
    end

    led_d = raw & {NCH{gate}};
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      presc_q   <= '0;
      tick_q    <= 1'b0;
      phase_q   <= '0;
      blink_q   <= 1'b0;
      stretch_q <= '0;
      pwm_q     <= '0;
      led_q     <= '0;
    end else begin
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      phase_q   <= phase_d;
      blink_q   <= blink_d;
      stretch_q <= stretch_d;
      pwm_q     <= pwm_d;
      led_q     <= led_d;
    end
  end

endmodule

// File: tb/tb_led_status_ctrl.sv
// Directed bench for led_status_ctrl with small parameters (4 channels,
// 10-cycle tick, 5-tick half period, 3-tick stretch, 4-bit PWM).
module tb_led_status_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic [7:0] mode;
  logic [3:0] evt;
  logic [3:0] duty;
  logic [3:0] led;
  logic       tick;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 sys_clk = ~sys_clk;

  led_status_ctrl #(
    .NCH               (4),
    .CLK_DIV           (10),
    .HALF_PERIOD_TICKS (5),
    .STRETCH_TICKS     (3),
    .PWM_BITS          (4)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .mode      (mode),
    .evt       (evt),
    .duty      (duty),
    .led       (led),
    .tick      (tick)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic step();
    @(posedge sys_clk);
    #1;
    cyc++;
  endtask

  // One reset edge; cyc counts edges after it (first released edge is cyc 1).
  task automatic do_reset(input logic [7:0] m);
    sys_rst_n = 1'b0;
    mode      = m;
    evt       = '0;
    step();
    cyc       = 0;
    sys_rst_n = 1'b1;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic wait_bit(input int idx, input logic val, input int limit, output int at);
    at = -1;
    for (int n = 0; n < limit; n++) begin
      step();
      if (led[idx] === val) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_tick(input int limit, output int at);
    at = -1;
    for (int n = 0; n < limit; n++) begin
      step();
      if (tick === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic count_high(input int idx, input int n, output int hi);
    hi = 0;
    for (int k = 0; k < n; k++) begin
      step();
      if (led[idx] === 1'b1) hi++;
    end
  endtask

  initial begin
    int bad;
    int at;
    int hi;

    sys_rst_n = 1'b0;
    mode      = 8'h55;
    evt       = '0;
    duty      = 4'hF;

    // Reset hold and tick cadence
    bad = 0;
    for (int n = 0; n < 5; n++) begin
      step();
      if (led !== 4'h0 || tick !== 1'b0) bad++;
    end
    check("rst_hold", bad, 0);
    sys_rst_n = 1'b1;
    cyc = 0;
    step();
    check("led_after_release", led, 4'hF);
    check("tick_after_release", tick, 1'b0);
    wait_tick(30, at);
    check("first_tick", at, 10);
    step();
    check("tick_width", tick, 1'b0);
    wait_tick(30, at);
    check("tick_gap1", at, 20);
    wait_tick(30, at);
    check("tick_gap2", at, 30);

    // Blink, all channels in phase
    do_reset(8'hAA);
    step();
    check("blink_start", led, 4'h0);
    wait_bit(0, 1'b1, 200, at);
    check("blink_rise1", at, 52);
    check("blink_phase_hi", led, 4'hF);
    wait_bit(0, 1'b0, 200, at);
    check("blink_fall1", at, 102);
    check("blink_phase_lo", led, 4'h0);
    wait_bit(0, 1'b1, 200, at);
    check("blink_rise2", at, 152);

    // Stretch: single event
    do_reset(8'h03);
    run_to(2);
    evt = 4'b0001;
    step();
    evt = '0;
    check("stretch_lat1", led, 4'h0);
    step();
    check("stretch_rise", led, 4'h1);
    wait_bit(0, 1'b0, 100, at);
    check("stretch_fall", at, 32);

    // Stretch: event coinciding with tick is loaded, not decremented
    do_reset(8'h03);
    run_to(10);
    check("tick_align", tick, 1'b1);
    evt = 4'b0001;
    step();
    evt = '0;
    wait_bit(0, 1'b1, 10, at);
    check("coinc_rise", at, 12);
    wait_bit(0, 1'b0, 100, at);
    check("coinc_fall", at, 42);

    // Stretch: retrigger while lit
    do_reset(8'h03);
    run_to(2);
    evt = 4'b0001;
    step();
    evt = '0;
    run_to(24);
    check("retrig_lit", led, 4'h1);
    evt = 4'b0001;
    step();
    evt = '0;
    wait_bit(0, 1'b0, 100, at);
    check("retrig_fall", at, 52);

    // PWM brightness
    do_reset(8'h55);
    duty = 4'd4;
    step();
    count_high(0, 16, hi);
    check("pwm_duty4", hi, 4);
    duty = 4'd9;
    step();
    count_high(0, 16, hi);
    check("pwm_duty9", hi, 9);
    duty = 4'd0;
    step();
    count_high(0, 32, hi);
    check("pwm_duty0", hi, 0);
    check("pwm_duty0_all", led, 4'h0);
    duty = 4'hF;
    step();
    count_high(0, 32, hi);
    check("pwm_dutyF", hi, 32);
    check("pwm_dutyF_all", led, 4'hF);

    // Mid-operation reset during a stretch
    do_reset(8'h03);
    run_to(2);
    evt = 4'b0001;
    step();
    evt = '0;
    run_to(15);
    check("pre_rst_lit", led, 4'h1);
    do_reset(8'h03);
    check("midrst_stretch", led, 4'h0);
    count_high(0, 40, hi);
    check("stretch_no_resume", hi, 0);

    // Mid-operation reset during blink high
    do_reset(8'hAA);
    run_to(60);
    check("pre_rst_blink", led, 4'hF);
    do_reset(8'hAA);
    check("midrst_blink", led, 4'h0);
    wait_bit(0, 1'b1, 200, at);
    check("blink_restart", at, 52);

    // Mode switching on ch1 with a background stretch counter
    do_reset(8'h0C);
    run_to(2);
    evt = 4'b0010;
    step();
    evt = '0;
    run_to(5);
    check("sw_lit", led, 4'h2);
    mode = 8'h04;
    step();
    check("sw_to_on", led, 4'h2);
    run_to(12);
    mode = 8'h0C;
    step();
    check("sw_back_live", led, 4'h2);
    wait_bit(1, 1'b0, 100, at);
    check("sw_bg_fall", at, 32);
    run_to(40);
    mode = 8'h04;
    step();
    check("sw_on_again", led, 4'h2);
    run_to(45);
    check("sw_hold_on", led, 4'h2);
    mode = 8'h0C;
    step();
    check("sw_back_expired", led, 4'h0);
    run_to(50);
    mode = 8'h04;
    evt  = 4'b0010;
    step();
    evt  = '0;
    run_to(55);
    mode = 8'h0C;
    step();
    check("sw_bg_load", led, 4'h2);
    wait_bit(1, 1'b0, 100, at);
    check("sw_bg_load_fall", at, 82);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
